// File: rtl/est_engine_seq.sv
// ICA source estimator: walks S = W'*Z one element at a time through an external
// dot-product unit, with start/busy handshake, backpressured stream, timeout and abort.
module est_engine_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 3,
    parameter int EXT_DIM    = 4,
    parameter int SAMPLES    = 4,
    parameter int TIMEOUT    = 64,
    localparam int RW        = (DIM > 1) ? $clog2(DIM) : 1,
    localparam int CW        = (SAMPLES > 1) ? $clog2(SAMPLES) : 1
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               en,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               mode,
    input  logic [DATA_WIDTH*DIM*SAMPLES-1:0]  Z_in,
    input  logic [DATA_WIDTH*DIM*DIM-1:0]      W_mat,
    output logic                               busy,
    output logic                               est_opvld,
    output logic                               err_timeout,
    output logic [DATA_WIDTH*DIM*SAMPLES-1:0]  S_est,
    output logic                               s_valid,
    input  logic                               s_ready,
    output logic [DATA_WIDTH-1:0]              s_data,
    output logic [RW-1:0]                      s_row,
    output logic [CW-1:0]                      s_col,
    output logic                               start_dot_product,
    output logic                               rstn_dot,
    input  logic                               dot_product_done,
    output logic [DATA_WIDTH*EXT_DIM-1:0]      vector_a,
    output logic [DATA_WIDTH*EXT_DIM-1:0]      vector_b,
    input  logic [DATA_WIDTH-1:0]              dot_product_result
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        EMIT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                            r_state;
    logic [DATA_WIDTH*DIM*DIM-1:0]     r_w;
    logic [DATA_WIDTH*DIM*SAMPLES-1:0] r_z;
    logic                              r_mode;
    logic [RW-1:0]                     r_k;
    logic [CW-1:0]                     r_n;
    logic [TW-1:0]                     r_tmo;

    logic [DATA_WIDTH*EXT_DIM-1:0]     w_a;
    logic [DATA_WIDTH*EXT_DIM-1:0]     w_b;
    int                                w_s_idx;

    // Operand selection from the captured frame; lanes at and above DIM stay zero.
    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_s_idx = int'(r_k) * SAMPLES + int'(r_n);
        for (int i = 0; i < DIM; i++) begin
            if (r_mode) begin
                w_a[i*DATA_WIDTH +: DATA_WIDTH] = r_w[(int'(r_k)*DIM + i)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                w_a[i*DATA_WIDTH +: DATA_WIDTH] = r_w[(i*DIM + int'(r_k))*DATA_WIDTH +: DATA_WIDTH];
            end
            w_b[i*DATA_WIDTH +: DATA_WIDTH] = r_z[(i*SAMPLES + int'(r_n))*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Sequencer FSM with all outputs registered; abort outranks en, start and done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state           <= IDLE;
            r_w               <= '0;
            r_z               <= '0;
            r_mode            <= 1'b0;
            r_k               <= '0;
            r_n               <= '0;
            r_tmo             <= '0;
            busy              <= 1'b0;
            est_opvld         <= 1'b0;
            err_timeout       <= 1'b0;
            S_est             <= '0;
            s_valid           <= 1'b0;
            s_data            <= '0;
            s_row             <= '0;
            s_col             <= '0;
            start_dot_product <= 1'b0;
            rstn_dot          <= 1'b0;
            vector_a          <= '0;
            vector_b          <= '0;
        end else if (abort) begin
            r_state           <= IDLE;
            busy              <= 1'b0;
            s_valid           <= 1'b0;
            start_dot_product <= 1'b0;
            rstn_dot          <= 1'b0;
            est_opvld         <= 1'b0;
        end else if (en) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_w         <= W_mat;
                        r_z         <= Z_in;
                        r_mode      <= mode;
                        r_k         <= '0;
                        r_n         <= '0;
                        busy        <= 1'b1;
                        est_opvld   <= 1'b0;
                        err_timeout <= 1'b0;
                        r_state     <= LOAD;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                LOAD: begin
                    vector_a <= w_a;
                    vector_b <= w_b;
                    rstn_dot <= 1'b1;
                    r_state  <= ISSUE;
                end
                ISSUE: begin
                    start_dot_product <= 1'b1;
                    r_tmo             <= '0;
                    r_state           <= WAIT;
                end
                WAIT: begin
                    if (dot_product_done) begin
                        S_est[w_s_idx*DATA_WIDTH +: DATA_WIDTH] <= dot_product_result;
                        s_data            <= dot_product_result;
                        s_row             <= r_k;
                        s_col             <= r_n;
                        s_valid           <= 1'b1;
                        start_dot_product <= 1'b0;
                        r_state           <= EMIT;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        err_timeout       <= 1'b1;
                        busy              <= 1'b0;
                        start_dot_product <= 1'b0;
                        rstn_dot          <= 1'b0;
                        r_state           <= IDLE;
                    end else begin
                        r_tmo             <= r_tmo + TW'(1);
                    end
                end
                EMIT: begin
                    if (s_ready) begin
                        s_valid  <= 1'b0;
                        rstn_dot <= 1'b0;
                        if (int'(r_n) < SAMPLES - 1) begin
                            r_n     <= r_n + CW'(1);
                            r_state <= LOAD;
                        end else if (int'(r_k) < DIM - 1) begin
                            r_n     <= '0;
                            r_k     <= r_k + RW'(1);
                            r_state <= LOAD;
                        end else begin
                            r_n     <= '0;
                            r_state <= DONE;
                        end
                    end else begin
                        r_state <= EMIT;
                    end
                end
                DONE: begin
                    est_opvld <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
